// File: rtl/pe_route_pkg.sv
// Shared types and link-field helpers for the three-port route tile.
// A link is {valid, dest[1:0], payload[DATA_WIDTH-1:0]}.
package pe_route_pkg;

  typedef enum logic [1:0] {
    DIR_EAST    = 2'd0,
    DIR_WEST    = 2'd1,
    DIR_NORTH   = 2'd2,
    DIR_INVALID = 2'd3
  } dir_t;

  localparam int NUM_PORTS = 3;

  function automatic int link_width(input int data_width);
    return data_width + 3;
  endfunction

  function automatic int valid_bit(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int dest_lsb(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/pe_route_fifo.sv
// Synchronous FIFO with registered occupancy; one extra count bit keeps
// full and empty distinct when the pointers coincide.
module pe_route_fifo #(
  parameter int WIDTH     = 129,
  parameter int ADDR_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    rd_ptr_d = rd_ptr_q + ADDR_BITS'(do_pop);
    wr_ptr_d = wr_ptr_q + ADDR_BITS'(do_push);
    count_d  = count_q + (ADDR_BITS + 1)'(do_push) - (ADDR_BITS + 1)'(do_pop);
  end

  // NOTE: storage is not reset; the occupancy count alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pe_route_tile.sv
// Three-port packet router tile: per-input FIFOs, per-output round-robin
// arbiters with registered outputs, and a saturating drop counter.
module pe_route_tile
  import pe_route_pkg::*;
#(
  parameter int  DATA_WIDTH     = 127,
  parameter int  FIFO_ADDR_BITS = 2,
  parameter int  DROP_CNT_WIDTH = 16,
  localparam int LINK_WIDTH     = link_width(DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ap_start,
  input  logic [LINK_WIDTH-1:0]     in_from_east,
  input  logic [LINK_WIDTH-1:0]     in_from_west,
  input  logic [LINK_WIDTH-1:0]     in_from_north,
  output logic                      in_from_east_rdy,
  output logic                      in_from_west_rdy,
  output logic                      in_from_north_rdy,
  output logic [LINK_WIDTH-1:0]     out_to_east,
  output logic [LINK_WIDTH-1:0]     out_to_west,
  output logic [LINK_WIDTH-1:0]     out_to_north,
  input  logic                      out_to_east_rdy,
  input  logic                      out_to_west_rdy,
  input  logic                      out_to_north_rdy,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int VALID_BIT  = valid_bit(DATA_WIDTH);
  localparam int DEST_LSB   = dest_lsb(DATA_WIDTH);
  localparam int FIFO_WIDTH = DATA_WIDTH + 2;

  logic [LINK_WIDTH-1:0]     in_link [NUM_PORTS];
  logic [NUM_PORTS-1:0]      out_rdy, in_rdy, push, pop, full, empty;
  logic [FIFO_WIDTH-1:0]     head [NUM_PORTS];
  logic [1:0]                head_dest [NUM_PORTS];
  logic [LINK_WIDTH-1:0]     out_q [NUM_PORTS];
  logic [LINK_WIDTH-1:0]     out_d [NUM_PORTS];
  logic [1:0]                ptr_q [NUM_PORTS];
  logic [1:0]                ptr_d [NUM_PORTS];
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_WIDTH:0]   drop_sum;
  logic [1:0]                n_drops;

  assign in_link[0] = in_from_east;
  assign in_link[1] = in_from_west;
  assign in_link[2] = in_from_north;
  assign out_rdy    = {out_to_north_rdy, out_to_west_rdy, out_to_east_rdy};
  assign in_rdy     = {NUM_PORTS{ap_start}} & ~full;

  assign in_from_east_rdy  = in_rdy[0];
  assign in_from_west_rdy  = in_rdy[1];
  assign in_from_north_rdy = in_rdy[2];
  assign out_to_east       = out_q[0];
  assign out_to_west       = out_q[1];
  assign out_to_north      = out_q[2];
  assign drop_count        = drop_cnt_q;

  // The valid bit is implied by FIFO occupancy, so only dest+payload is stored.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in
    assign push[g]      = in_link[g][VALID_BIT] & in_rdy[g];
    assign head_dest[g] = head[g][FIFO_WIDTH-1:DEST_LSB];

    pe_route_fifo #(
      .WIDTH     (FIFO_WIDTH),
      .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (in_link[g][FIFO_WIDTH-1:0]),
      .head_data (head[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin : route_comb
    logic found;
    int   win;
    int   idx;
    pop     = '0;
    n_drops = '0;
    found   = 1'b0;
    win     = 0;
    idx     = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_d[o] = out_q[o];
      ptr_d[o] = ptr_q[o];
    end

    if (ap_start) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!empty[i] && (head_dest[i] == 2'(i) || head_dest[i] == DIR_INVALID)) begin
          pop[i]  = 1'b1;
          n_drops = n_drops + 2'd1;
        end
      end

      // A head addressed to its own port is a drop, never a candidate.
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (!out_q[o][VALID_BIT] || out_rdy[o]) begin
          found = 1'b0;
          win   = 0;
          for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr_q[o]) + k) % NUM_PORTS;
            if (!found && !empty[idx] && idx != o && head_dest[idx] == 2'(o)) begin
              found = 1'b1;
              win   = idx;
            end
          end
          if (found) begin
            out_d[o] = {1'b1, head[win]};
            pop[win] = 1'b1;
            ptr_d[o] = 2'((win + 1) % NUM_PORTS);
          end else if (out_rdy[o]) begin
            out_d[o] = '0;
          end
        end
      end
    end

    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_WIDTH + 1)'(n_drops);
    drop_cnt_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_q[o] <= '0;
        ptr_q[o] <= 2'(DIR_EAST);
      end
      drop_cnt_q <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_q[o] <= out_d[o];
        ptr_q[o] <= ptr_d[o];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pe_route_tile.sv
// Bench for pe_route_tile: directed scenarios plus random traffic, all
// compared against a queue-based transaction model of the router.
module tb_pe_route_tile;

  localparam int DW    = 127;
  localparam int LW    = DW + 3;
  localparam int FW    = DW + 2;
  localparam int VB    = DW + 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start;
  logic [LW-1:0] in_from_east, in_from_west, in_from_north;
  logic          in_from_east_rdy, in_from_west_rdy, in_from_north_rdy;
  logic [LW-1:0] out_to_east, out_to_west, out_to_north;
  logic          out_to_east_rdy, out_to_west_rdy, out_to_north_rdy;
  logic [15:0]   drop_count;

  pe_route_tile dut (
    .clk               (clk),
    .reset             (reset),
    .ap_start          (ap_start),
    .in_from_east      (in_from_east),
    .in_from_west      (in_from_west),
    .in_from_north     (in_from_north),
    .in_from_east_rdy  (in_from_east_rdy),
    .in_from_west_rdy  (in_from_west_rdy),
    .in_from_north_rdy (in_from_north_rdy),
    .out_to_east       (out_to_east),
    .out_to_west       (out_to_west),
    .out_to_north      (out_to_north),
    .out_to_east_rdy   (out_to_east_rdy),
    .out_to_west_rdy   (out_to_west_rdy),
    .out_to_north_rdy  (out_to_north_rdy),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] dout [3];
  logic          drdy [3];
  assign dout[0] = out_to_east;
  assign dout[1] = out_to_west;
  assign dout[2] = out_to_north;
  assign drdy[0] = in_from_east_rdy;
  assign drdy[1] = in_from_west_rdy;
  assign drdy[2] = in_from_north_rdy;

  // Stimulus held by the bench and applied on each tick.
  bit          in_v [3];
  logic [1:0]  in_d [3];
  logic [DW-1:0] in_p [3];
  bit          ordy [3];
  bit          start;

  // Reference model: input queues, output registers, pointers, drop total.
  logic [FW-1:0] mq [3][$];
  logic [LW-1:0] mout [3];
  int            mptr [3];
  int            mdc;

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mout[i] = '0;
      mptr[i] = 0;
    end
    mdc = 0;
  endtask

  task automatic model_step();
    bit            acc [3];
    bit            take [3];
    logic [LW-1:0] nout [3];
    int            nptr [3];
    logic [FW-1:0] h;
    int            nd, idx;
    bit            got;
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      acc[i]  = in_v[i] && start && (mq[i].size() < DEPTH);
      take[i] = 0;
      nout[i] = mout[i];
      nptr[i] = mptr[i];
    end
    if (start) begin
      for (int i = 0; i < 3; i++) begin
        if (mq[i].size() > 0) begin
          h = mq[i][0];
          if (int'(h[FW-1:DW]) == i || h[FW-1:DW] == 2'd3) begin
            take[i] = 1;
            nd++;
          end
        end
      end
      for (int o = 0; o < 3; o++) begin
        if (!mout[o][VB] || ordy[o]) begin
          got = 0;
          for (int k = 0; k < 3; k++) begin
            idx = (mptr[o] + k) % 3;
            if (!got && idx != o && mq[idx].size() > 0) begin
              h = mq[idx][0];
              if (int'(h[FW-1:DW]) == o) begin
                got = 1;
                nout[o] = {1'b1, h};
                take[idx] = 1;
                nptr[o] = (idx + 1) % 3;
              end
            end
          end
          if (!got && ordy[o]) nout[o] = '0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (take[i]) void'(mq[i].pop_front());
      if (acc[i]) mq[i].push_back({in_d[i], in_p[i]});
      mout[i] = nout[i];
      mptr[i] = nptr[i];
    end
    mdc = (mdc + nd > 65535) ? 65535 : mdc + nd;
  endtask

  task automatic apply_inputs();
    in_from_east     = {in_v[0], in_d[0], in_p[0]};
    in_from_west     = {in_v[1], in_d[1], in_p[1]};
    in_from_north    = {in_v[2], in_d[2], in_p[2]};
    out_to_east_rdy  = ordy[0];
    out_to_west_rdy  = ordy[1];
    out_to_north_rdy = ordy[2];
    ap_start         = start;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    apply_inputs();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_v[i] = 0;
      in_d[i] = '0;
      in_p[i] = '0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < 3; i++) ordy[i] = 1;
    start = 0;
    reset = 1'b1;
    apply_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int o = 0; o < 3; o++) begin
      checks++;
      if (dout[o] !== '0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got %h expected 0", o, dout[o]);
      end
      checks++;
      if (drdy[o] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rdy_idle[%0d]: got %b expected 0", o, drdy[o]);
      end
    end
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop: got %0d expected 0", drop_count);
    end
    start = 1;
    apply_inputs();
    #1;
    for (int o = 0; o < 3; o++) begin
      checks++;
      if (drdy[o] !== 1'b1) begin
        errors++;
        $display("FAIL reset_rdy_start[%0d]: got %b expected 1", o, drdy[o]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [LW-1:0] exp_n;
    exp_n = {1'b1, 2'd2, 127'h5A};
    in_v[0] = 1; in_d[0] = 2'd2; in_p[0] = 127'h5A;
    tick();
    idle_inputs();
    checks++;
    if (out_to_north[VB] !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: out_to_north valid %b expected 0", out_to_north[VB]);
    end
    tick();
    checks++;
    if (out_to_north !== exp_n) begin
      errors++;
      $display("FAIL basic_north: got %h expected %h", out_to_north, exp_n);
    end
    checks++;
    if (out_to_east !== '0 || out_to_west !== '0) begin
      errors++;
      $display("FAIL basic_others: east %h west %h expected 0", out_to_east, out_to_west);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int src_q [$];
    for (int t = 0; t < 24; t++) begin
      idle_inputs();
      if (t < 8) begin
        in_v[1] = 1; in_d[1] = 2'd0; in_p[1] = DW'(32'h100 + t);
        in_v[2] = 1; in_d[2] = 2'd0; in_p[2] = DW'(32'h200 + t);
      end
      tick();
      checks++;
      if (out_to_east !== mout[0]) begin
        errors++;
        $display("FAIL rr_model t=%0d: got %h expected %h", t, out_to_east, mout[0]);
      end
      if (out_to_east[VB]) src_q.push_back(int'(out_to_east[11:8]));
    end
    checks++;
    if (src_q.size() < 8) begin
      errors++;
      $display("FAIL rr_count: got %0d outputs expected at least 8", src_q.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (src_q[j] != ((j % 2 == 0) ? 1 : 2)) begin
          errors++;
          $display("FAIL rr_order[%0d]: got source %0d expected %0d", j, src_q[j], (j % 2 == 0) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int got_q [$];
    int sent;
    bit acc;
    idle_inputs();
    ordy[1] = 0;
    for (int t = 0; t < 6; t++) begin
      in_v[0] = 1; in_d[0] = 2'd1; in_p[0] = DW'(32'h300 + t);
      apply_inputs();
      #1;
      checks++;
      if (in_from_east_rdy !== ((t < 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bp_rdy after %0d accepts: got %b expected %b", t, in_from_east_rdy, (t < 5));
      end
      if (t < 5) tick();
    end
    sent = 5;
    ordy[1] = 1;
    for (int t = 0; t < 40; t++) begin
      if (sent < 6) begin
        in_v[0] = 1; in_d[0] = 2'd1; in_p[0] = DW'(32'h300 + sent);
      end else begin
        in_v[0] = 0;
      end
      apply_inputs();
      #1;
      acc = in_v[0] && in_from_east_rdy;
      if (out_to_west[VB] && out_to_west_rdy) got_q.push_back(int'(out_to_west[15:0]));
      tick();
      if (acc) sent++;
    end
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d packets expected 6", got_q.size());
    end
    for (int j = 0; j < got_q.size() && j < 6; j++) begin
      checks++;
      if (got_q[j] != 32'h300 + j) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %h expected %h", j, got_q[j], 32'h300 + j);
      end
    end
    idle_inputs();
  endtask

  task automatic test_drop();
    idle_inputs();
    for (int t = 0; t < 5; t++) begin
      idle_inputs();
      if (t == 0) begin in_v[0] = 1; in_d[0] = 2'd0; in_p[0] = 127'h77; end
      if (t == 1) begin in_v[0] = 1; in_d[0] = 2'd3; in_p[0] = 127'h78; end
      tick();
      for (int o = 0; o < 3; o++) begin
        checks++;
        if (dout[o][VB] !== 1'b0) begin
          errors++;
          $display("FAIL drop_leak t=%0d out[%0d]: got %h expected invalid", t, o, dout[o]);
        end
      end
    end
    checks++;
    if (drop_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_count: got %0d expected 2", drop_count);
    end
  endtask

  task automatic test_pause();
    logic [LW-1:0] exp_a, exp_b;
    exp_a = {1'b1, 2'd1, 127'h400};
    exp_b = {1'b1, 2'd1, 127'h401};
    idle_inputs();
    in_v[0] = 1; in_d[0] = 2'd1; in_p[0] = 127'h400;
    tick();
    in_p[0] = 127'h401;
    tick();
    idle_inputs();
    start = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (out_to_west !== exp_a) begin
        errors++;
        $display("FAIL pause_hold t=%0d: got %h expected %h", t, out_to_west, exp_a);
      end
      checks++;
      if ({in_from_east_rdy, in_from_west_rdy, in_from_north_rdy} !== 3'b000) begin
        errors++;
        $display("FAIL pause_rdy t=%0d: got %b expected 000", t,
                 {in_from_east_rdy, in_from_west_rdy, in_from_north_rdy});
      end
    end
    start = 1;
    tick();
    checks++;
    if (out_to_west !== exp_b) begin
      errors++;
      $display("FAIL pause_resume: got %h expected %h", out_to_west, exp_b);
    end
    tick();
    checks++;
    if (out_to_west[VB] !== 1'b0) begin
      errors++;
      $display("FAIL pause_drain: got %h expected invalid", out_to_west);
    end
  endtask

  task automatic test_random();
    logic [127:0] r;
    int printed = 0;
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < 3; i++) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        in_v[i] = ($urandom_range(0, 9) < 6);
        in_d[i] = 2'($urandom_range(0, 3));
        in_p[i] = r[DW-1:0];
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      start = ($urandom_range(0, 9) != 0);
      tick();
      for (int o = 0; o < 3; o++) begin
        checks++;
        if (dout[o] !== mout[o]) begin
          errors++;
          if (printed++ < 20) $display("FAIL rand_out[%0d] t=%0d: got %h expected %h", o, t, dout[o], mout[o]);
        end
        checks++;
        if (drdy[o] !== (start && mq[o].size() < DEPTH)) begin
          errors++;
          if (printed++ < 20) $display("FAIL rand_rdy[%0d] t=%0d: got %b expected %b", o, t, drdy[o],
                                       (start && mq[o].size() < DEPTH));
        end
      end
      checks++;
      if (int'(drop_count) != mdc) begin
        errors++;
        if (printed++ < 20) $display("FAIL rand_drop t=%0d: got %0d expected %0d", t, drop_count, mdc);
      end
    end
    start = 1;
    idle_inputs();
    for (int i = 0; i < 3; i++) ordy[i] = 1;
    repeat (12) tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      in_v[i] = 1;
      in_d[i] = 2'(i);
      in_p[i] = DW'(32'hD00 + i);
      ordy[i] = 1;
    end
    repeat (22000) tick();
    checks++;
    if (drop_count !== 16'hFFFF || mdc != 65535) begin
      errors++;
      $display("FAIL sat_reach: got %h expected FFFF (model %0d)", drop_count, mdc);
    end
    repeat (4) tick();
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h expected FFFF", drop_count);
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] exp_n;
    idle_inputs();
    ordy[2] = 0;
    for (int t = 0; t < 3; t++) begin
      in_v[0] = 1; in_d[0] = 2'd2; in_p[0] = DW'(32'h500 + t);
      in_v[1] = (t < 2); in_d[1] = 2'd2; in_p[1] = DW'(32'h600 + t);
      tick();
    end
    idle_inputs();
    checks++;
    if (out_to_north[VB] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: out_to_north valid %b expected 1", out_to_north[VB]);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int o = 0; o < 3; o++) begin
      checks++;
      if (dout[o] !== '0) begin
        errors++;
        $display("FAIL rstmid_async[%0d]: got %h expected 0", o, dout[o]);
      end
    end
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_drop: got %0d expected 0", drop_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) ordy[i] = 1;
    for (int t = 0; t < 6; t++) begin
      tick();
      for (int o = 0; o < 3; o++) begin
        checks++;
        if (dout[o] !== '0) begin
          errors++;
          $display("FAIL rstmid_stale t=%0d out[%0d]: got %h expected 0", t, o, dout[o]);
        end
      end
    end
    in_v[0] = 1; in_d[0] = 2'd2; in_p[0] = 127'h5B;
    tick();
    idle_inputs();
    tick();
    exp_n = {1'b1, 2'd2, 127'h5B};
    checks++;
    if (out_to_north !== exp_n) begin
      errors++;
      $display("FAIL rstmid_after: got %h expected %h", out_to_north, exp_n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_pause();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
